// File: rtl/prng_pkg.sv
// prng_pkg: shared FSM state type, default LFSR constants and the symmetric clamp/sign-extend helper
package prng_pkg;
  typedef enum logic [1:0] {IDLE, STEP, HOLD} prng_state_t;
  localparam logic [31:0] TAPS_DEFAULT = 32'hA3000000;
  localparam logic [31:0] SEED_DEFAULT = 32'h8EAF696C;
  function automatic logic [31:0] clamp_sext(input logic [15:0] raw, input int w);
    logic [31:0] mask, v;
    mask = (32'd1 << w) - 32'd1;
    v = {16'd0, raw} & mask;
    return (v == (32'd1 << (w - 1))) ? 32'd0 : (v[w-1] ? (v | ~mask) : v);
  endfunction
endpackage

// File: rtl/prng_lfsr_ch.sv
// prng_lfsr_ch: one Fibonacci LFSR channel (clock, reset, step, load, load_value in; next-state out) with zero-seed guard
module prng_lfsr_ch #(
  parameter int W = 32,
  parameter logic [W-1:0] TAPS = '0,
  parameter logic [W-1:0] INIT = '1,
  parameter logic [W-1:0] DEFAULT_SEED = '1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         step,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic [W-1:0] next
);
  logic [W-1:0] state;
  assign next = {state[W-2:0], ^(state & TAPS)};
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= INIT;
    else if (load) state <= (load_value == '0) ? DEFAULT_SEED : load_value;
    else if (step) state <= next;
endmodule

// File: rtl/prng_bank.sv
// prng_bank: NUM_CH LFSR noise channels; seed load (seed_load/seed_ch/seed_value/seed_ack), req/rsp sample handshake, rsp_data and sample_count out
module prng_bank
  import prng_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int LFSR_W = 32,
  parameter logic [LFSR_W-1:0] TAPS = LFSR_W'(TAPS_DEFAULT),
  parameter logic [LFSR_W-1:0] DEFAULT_SEED = LFSR_W'(SEED_DEFAULT),
  parameter int OUT_W = 4,
  parameter int STEPS_PER_SAMPLE = 4,
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  free_run,
  input  logic                  seed_load,
  input  logic [CH_W-1:0]       seed_ch,
  input  logic [LFSR_W-1:0]     seed_value,
  output logic                  seed_ack,
  input  logic                  req_valid,
  output logic                  req_ready,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [32*NUM_CH-1:0]  rsp_data,
  output logic [15:0]           sample_count
);
  prng_state_t state, state_nx;
  logic [7:0] cnt;
  logic accept, load_ok, step_all, last;
  logic [LFSR_W-1:0] next [NUM_CH];
  logic [32*NUM_CH-1:0] sample;
  assign accept = state == IDLE && req_valid;
  assign load_ok = state == IDLE && seed_load && 32'(seed_ch) < NUM_CH;
  assign step_all = state == STEP || (state == IDLE && free_run && !req_valid);
  assign last = state == STEP && cnt == 8'd0;
  assign req_ready = state == IDLE;
  assign rsp_valid = state == HOLD;
  always_comb
    state_nx = state == IDLE ? (req_valid ? STEP : IDLE) :
               state == STEP ? (cnt == 8'd0 ? HOLD : STEP) :
               (rsp_ready ? IDLE : HOLD);
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    localparam int R = (8 * c) % LFSR_W;
    localparam logic [LFSR_W-1:0] INIT = (DEFAULT_SEED << R) | (DEFAULT_SEED >> ((LFSR_W - R) % LFSR_W));
    prng_lfsr_ch #(.W(LFSR_W), .TAPS(TAPS), .INIT(INIT), .DEFAULT_SEED(DEFAULT_SEED)) u_ch (
      .clock,
      .reset,
      .step(step_all),
      .load(load_ok && 32'(seed_ch) == c),
      .load_value(seed_value),
      .next(next[c])
    );
    assign sample[32*c +: 32] = clamp_sext(16'(next[c][OUT_W-1:0]), OUT_W);
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      rsp_data <= '0;
      seed_ack <= 1'b0;
      sample_count <= '0;
    end else begin
      state <= state_nx;
      seed_ack <= load_ok;
      if (accept) cnt <= 8'(STEPS_PER_SAMPLE - 1);
      else if (state == STEP && cnt != 8'd0) cnt <= cnt - 8'd1;
      if (last) rsp_data <= sample;
      if (state == HOLD && rsp_ready) sample_count <= sample_count + 16'd1;
    end
endmodule

// File: tb/tb_prng_bank.sv
// tb_prng_bank: self-checking bench for prng_bank against a transaction-level LFSR model
module tb_prng_bank;
  localparam logic [31:0] TAPS = 32'hA3000000, SEED = 32'h8EAF696C;
  localparam int S = 4;
  logic clock = 0, reset = 1;
  logic free_run = 0, seed_load = 0, req_valid = 0, rsp_ready = 0;
  logic [1:0] seed_ch = 0;
  logic [31:0] seed_value = 0;
  logic seed_ack, req_ready, rsp_valid;
  logic [127:0] rsp_data;
  logic [15:0] sample_count;
  logic req_valid1 = 0, rsp_ready1 = 0, seed_ack1, req_ready1, rsp_valid1;
  logic [127:0] rsp_data1;
  logic [15:0] sample_count1;
  int n_cmp = 0, n_err = 0;
  logic [31:0] m [4];
  logic [31:0] m1 [4];
  logic [15:0] exp_cnt;
  typedef struct {int ch; logic [31:0] value; logic fr; logic [31:0] exp_state;} seed_vec_t;
  seed_vec_t tbl [4];

  always #5 clock = ~clock;

  prng_bank dut (
    .clock, .reset, .free_run, .seed_load, .seed_ch, .seed_value, .seed_ack,
    .req_valid, .req_ready, .rsp_valid, .rsp_ready, .rsp_data, .sample_count
  );

  prng_bank #(.STEPS_PER_SAMPLE(1)) dut1 (
    .clock, .reset, .free_run(1'b0), .seed_load(1'b0), .seed_ch(2'd0), .seed_value(32'd0),
    .seed_ack(seed_ack1), .req_valid(req_valid1), .req_ready(req_ready1), .rsp_valid(rsp_valid1),
    .rsp_ready(rsp_ready1), .rsp_data(rsp_data1), .sample_count(sample_count1)
  );

  initial begin
    #5000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(negedge clock);
  endtask

  function automatic logic [31:0] nxt(input logic [31:0] s);
    return {s[30:0], ^(s & TAPS)};
  endfunction

  function automatic int smp(input logic [31:0] s);
    int v = int'(s[3:0]);
    return v == 8 ? 0 : (v > 7 ? v - 16 : v);
  endfunction

  function automatic logic [31:0] rot_seed(input int c);
    logic [31:0] s = SEED;
    repeat (8 * c) s = {s[30:0], s[31]};
    return s;
  endfunction

  task automatic reset_models;
    for (int c = 0; c < 4; c++) begin
      m[c] = rot_seed(c);
      m1[c] = rot_seed(c);
    end
    exp_cnt = 0;
  endtask

  task automatic idle(input int n, input logic f);
    free_run = f;
    repeat (n) begin
      tick;
      if (f) for (int c = 0; c < 4; c++) m[c] = nxt(m[c]);
    end
    free_run = 0;
  endtask

  task automatic seed(input int ch, input logic [31:0] v, input logic f, input logic [31:0] e);
    seed_load = 1;
    seed_ch = 2'(ch);
    seed_value = v;
    free_run = f;
    tick;
    seed_load = 0;
    free_run = 0;
    for (int c = 0; c < 4; c++)
      if (c == ch) m[c] = e;
      else if (f) m[c] = nxt(m[c]);
    check("seed_ack", 32'(seed_ack), 1);
    tick;
    check("seed_ack_fall", 32'(seed_ack), 0);
  endtask

  task automatic sample(input int hold, input logic fr, input logic with_seed, input int sch,
                        input logic [31:0] sv, input logic drop);
    int n = 0;
    logic [31:0] held;
    check("req_ready", 32'(req_ready), 1);
    free_run = fr;
    req_valid = 1;
    if (with_seed) begin
      seed_load = 1;
      seed_ch = 2'(sch);
      seed_value = sv;
    end
    tick;
    req_valid = 0;
    seed_load = drop;
    seed_ch = 2'd2;
    seed_value = 32'h1;
    if (with_seed) begin
      m[sch] = sv == 0 ? SEED : sv;
      check("seed_ack_accept", 32'(seed_ack), 1);
    end
    for (int c = 0; c < 4; c++) repeat (S) m[c] = nxt(m[c]);
    while (!rsp_valid && n < 64) begin
      tick;
      n++;
      check("seed_ack_busy", 32'(seed_ack), 0);
    end
    check("latency", n, S);
    for (int c = 0; c < 4; c++) check("rsp_data", rsp_data[32*c +: 32], smp(m[c]));
    held = rsp_data[31:0];
    for (int i = 0; i < hold; i++) begin
      tick;
      check("hold_valid", 32'(rsp_valid), 1);
      check("hold_data", rsp_data[31:0], smp(m[0]));
    end
    rsp_ready = 1;
    tick;
    rsp_ready = 0;
    seed_load = 0;
    free_run = 0;
    exp_cnt = exp_cnt + 16'd1;
    check("rsp_valid_drop", 32'(rsp_valid), 0);
    check("sample_count", 32'(sample_count), 32'(exp_cnt));
    check("rsp_data_kept", rsp_data[31:0], held);
  endtask

  task automatic sample1(output logic [127:0] d);
    int n = 0;
    req_valid1 = 1;
    tick;
    req_valid1 = 0;
    while (!rsp_valid1 && n < 16) begin
      tick;
      n++;
    end
    check("latency1", n, 1);
    d = rsp_data1;
    rsp_ready1 = 1;
    tick;
    rsp_ready1 = 0;
    check("rsp_valid1_drop", 32'(rsp_valid1), 0);
    for (int c = 0; c < 4; c++) m1[c] = nxt(m1[c]);
  endtask

  initial begin
    logic [127:0] d;
    logic [31:0] rv;
    int sv;
    reset_models();
    tbl[0] = '{2, 32'h0, 1'b0, SEED};
    tbl[1] = '{1, 32'h1, 1'b0, 32'h1};
    tbl[2] = '{3, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF};
    tbl[3] = '{0, 32'h12345678, 1'b1, 32'h12345678};
    tick;
    tick;
    reset = 0;
    check("rst_req_ready", 32'(req_ready), 1);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_data", 32'(|rsp_data), 0);
    check("rst_seed_ack", 32'(seed_ack), 0);
    check("rst_count", 32'(sample_count), 0);
    idle(5, 1'b0);
    check("idle_req_ready", 32'(req_ready), 1);
    check("idle_rsp_valid", 32'(rsp_valid), 0);
    check("idle_count", 32'(sample_count), 0);

    sample1(d);
    check("s1_first", d[31:0], 32'h0);
    for (int c = 0; c < 4; c++) check("s1_model", d[32*c +: 32], smp(m1[c]));
    sample1(d);
    check("s1_second", d[31:0], 32'h1);
    for (int c = 0; c < 4; c++) check("s1_model", d[32*c +: 32], smp(m1[c]));
    check("s1_count", 32'(sample_count1), 2);

    sample(10, 1'b1, 1'b0, 0, 0, 1'b0);
    for (int i = 0; i < 4; i++) seed(tbl[i].ch, tbl[i].value, tbl[i].fr, tbl[i].exp_state);
    sample(0, 1'b0, 1'b0, 0, 0, 1'b0);
    sample(2, 1'b1, 1'b0, 0, 0, 1'b1);
    sample(0, 1'b0, 1'b1, 2, 32'h0, 1'b0);

    req_valid = 1;
    tick;
    req_valid = 0;
    tick;
    check("in_step", 32'(req_ready), 0);
    #2 reset = 1;
    #1;
    check("mid_rst_valid", 32'(rsp_valid), 0);
    check("mid_rst_ready", 32'(req_ready), 1);
    check("mid_rst_data", 32'(|rsp_data), 0);
    check("mid_rst_count", 32'(sample_count), 0);
    tick;
    reset = 0;
    reset_models();
    sample(0, 1'b0, 1'b0, 0, 0, 1'b0);

    force dut.sample_count = 16'hFFFF;
    tick;
    release dut.sample_count;
    exp_cnt = 16'hFFFF;
    check("forced_count", 32'(sample_count), 32'hFFFF);
    sample(1, 1'b0, 1'b0, 0, 0, 1'b0);

    for (int it = 0; it < 200; it++) begin
      if ($urandom_range(3) == 0) begin
        rv = $urandom_range(7) == 0 ? 32'h0 : $urandom;
        seed($urandom_range(3), rv, 1'($urandom_range(1)), rv == 0 ? SEED : rv);
      end
      idle($urandom_range(5), 1'($urandom_range(1)));
      rv = $urandom_range(3) == 0 ? 32'h0 : $urandom;
      sample($urandom_range(4), 1'($urandom_range(1)), $urandom_range(3) == 0, $urandom_range(3), rv,
             $urandom_range(3) == 0);
    end

    for (int it = 0; it < 10000; it++) begin
      sample1(d);
      for (int c = 0; c < 4; c++) begin
        sv = $signed(d[32*c +: 32]);
        check("range", 32'(sv >= -7 && sv <= 7), 1);
        check("s1_model", d[32*c +: 32], smp(m1[c]));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/prng_bank.md
Name: prng_bank

Overview:
- Multi-channel, parametrised successor to the single 32-bit free-running LFSR noise source.
- NUM_CH independent Fibonacci LFSRs, each with a run-time loadable seed and lock-up protection.
- Samples are delivered through a req/rsp valid-ready handshake, with a configurable number of decorrelation steps per sample.
- Each channel returns a signed OUT_W-bit value with a symmetric range, sign-extended to 32 bits. Feeds the CPU's random-number MMIO/register path and other consumers of bounded random offsets.

Parameters:
- NUM_CH, 4: number of independent LFSR channels (1..8).
- LFSR_W, 32: LFSR state width.
- TAPS, 32'hA3000000: feedback mask. Bits 31, 29, 25 and 24 are set.
- DEFAULT_SEED, 32'h8EAF696C: reset seed. Must be non-zero.
- OUT_W, 4: signed sample width, 2..16.
- STEPS_PER_SAMPLE, 4: LFSR shifts per delivered sample, 1..255.

Ports:
- clock, input, 1: system clock.
- reset, input, 1: asynchronous, active-high.
- free_run, input, 1: when 1 and in IDLE, all LFSRs shift every cycle.
- seed_load, input, 1: request to load seed_value into channel seed_ch.
- seed_ch, input, $clog2(NUM_CH) (min 1): target channel for the seed load.
- seed_value, input, LFSR_W: seed to load.
- seed_ack, output, 1: one-cycle pulse when a seed was applied.
- req_valid, input, 1: sample request.
- req_ready, output, 1: block can accept a request.
- rsp_valid, output, 1: rsp_data is valid.
- rsp_ready, input, 1: consumer accepts the response.
- rsp_data, output, 32*NUM_CH: channel c occupies bits [32c+31:32c].
- sample_count, output, 16: number of responses delivered.

Behaviour:
- Reset is asynchronous, active-high (reset), on clock clock.
  - Channel c state becomes DEFAULT_SEED rotated left by 8*c (mod LFSR_W).
  - FSM goes to IDLE.
  - Outputs: req_ready=1, rsp_valid=0, rsp_data=0, seed_ack=0, sample_count=0.
- Step function, per channel: fb = XOR-reduce(state & TAPS); next = {state[LFSR_W-2:0], fb}.
- Sample function: raw = state[OUT_W-1:0] taken after the final step.
  - If raw == {1'b1, (OUT_W-1) zeros}, i.e. the most-negative value, the sample is 0. This keeps the range symmetric.
  - Otherwise the sample is raw, sign-extended to 32 bits.
- FSM states:
  - IDLE: req_ready=1.
    - On req_valid&&req_ready, step counter <= STEPS_PER_SAMPLE-1 and go to STEP.
    - Otherwise, if free_run=1, every LFSR steps each cycle.
  - STEP: req_ready=0. Every LFSR steps once per cycle.
    - When the counter is 0, latch the sample of the next state into rsp_data, set rsp_valid=1 and go to HOLD.
    - Otherwise decrement the counter.
  - HOLD: rsp_valid=1 and rsp_data stable. LFSRs frozen, even with free_run=1.
    - On rsp_ready, rsp_valid=0, sample_count increments (16-bit wrap, 16'hFFFF -> 0) and go to IDLE.
- Latency: a request accepted at edge k gives rsp_valid high after edge k+STEPS_PER_SAMPLE. One request is in flight at a time.
- rsp_data holds its last value after rsp_valid drops.
- Seed load:
  - Honoured only in IDLE. seed_ack pulses on the edge after the load.
  - In STEP or HOLD the load is dropped and there is no ack.
  - A seed_value of 0 is replaced by DEFAULT_SEED, because the all-zero state is lock-up.
  - seed_ch >= NUM_CH: the load is ignored, with no ack.
- Simultaneous seed_load and request accept in IDLE: the seed is written that edge, stepping starts on the next edge from the new seed, and seed_ack is still issued.
- Simultaneous seed_load and free_run: the seed wins for the target channel; other channels step.
- Reset mid-STEP or mid-HOLD: the in-flight response is discarded and all reset values apply immediately.

Decomposition:
- Shared package prng_pkg holds:
  - state enum IDLE/STEP/HOLD;
  - default TAPS and DEFAULT_SEED constants;
  - a function for symmetric clamp and sign-extend.
- One sub-module, prng_lfsr_ch: a single channel with state register, step enable, seed load and zero-seed guard. Instantiated NUM_CH times.
- The top level contains the FSM, step counter, response register and sample counter.

Test Plan:
- Reset, then idle 5 cycles with free_run=0: ch0 state stays 32'h8EAF696C, ch1 stays 32'hAF696C8E, req_ready=1, rsp_valid=0, sample_count=0.
- STEPS_PER_SAMPLE=1, one request from reset: ch0 state becomes 32'h1D5ED2D8, raw=4'b1000 is clamped, so rsp_data[31:0]=32'h00000000. A second request: state 32'h3ABDA5B1, rsp_data[31:0]=32'h00000001, sample_count=2 after both handshakes.
- Default STEPS=4: rsp_valid rises exactly 4 cycles after acceptance. Hold rsp_ready=0 for 10 cycles with free_run=1: rsp_data is unchanged and the LFSRs are frozen.
- seed_load with seed_ch=2 and seed_value=0 in IDLE: ch2 state becomes 32'h8EAF696C and seed_ack pulses. The same load issued during STEP is dropped with no ack.
- Assert reset mid-STEP: rsp_valid stays 0 and the state returns to the rotated seeds. sample_count wraps from 16'hFFFF to 0 after 65536 samples, exercised with a forced counter value.
- Over 10000 samples with OUT_W=4: every value lies in -7..7 and 4'b1000 never appears.
